// File: rtl/ecc_pkg.sv
// Shared constants and types for the 42-bit SECDED read-path stages.
package ecc_pkg;

  localparam int unsigned DATA_WIDTH   = 42;
  localparam int unsigned PARITY_WIDTH = 7;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SBIT = 2'b01;
  localparam logic [1:0] ERR_DBIT = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ecc_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered in_ready.
module ecc_skid_buf
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = 43
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             in_xfer, out_xfer;

  assign out_valid   = (state_q != EMPTY);
  assign out_payload = main_q;
  assign in_xfer     = in_valid & in_ready;
  assign out_xfer    = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is a flop tracking the next state, so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != TWO);
      if (load_main_in)   main_q <= in_payload;
      if (load_main_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_payload;
    end
  end

endmodule

// File: rtl/ecc_42_rd_stage.sv
// Read-side stage after the 42-bit SECDED decoder: skid buffering plus
// saturating error counters, first-error capture and double-bit interrupt.
module ecc_42_rd_stage
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ecc_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_dbit_err,
  input  logic                  clr_err,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic                  err_vld,
  output logic [1:0]            err_type,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  irq_dbit
);

  logic       acc, acc_sbit, acc_dbit;
  logic [1:0] new_type;

  ecc_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  ({in_dbit_err, in_data}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload ({out_dbit_err, out_data})
  );

  // A word flagged both sbit and dbit counts as dbit only.
  assign acc      = in_valid & in_ready;
  assign acc_dbit = acc & in_dbit_err;
  assign acc_sbit = acc & in_sbit_err & ~in_dbit_err;
  assign new_type = acc_dbit ? ERR_DBIT : ERR_SBIT;
  assign irq_dbit = err_vld & (err_type == ERR_DBIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else if (clr_err) begin
      sbit_cnt <= acc_sbit ? CNT_WIDTH'(1) : '0;
      dbit_cnt <= acc_dbit ? CNT_WIDTH'(1) : '0;
    end else begin
      if (acc_sbit && sbit_cnt != '1) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      if (acc_dbit && dbit_cnt != '1) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
    end
  end

  // Capture keeps the first error, upgraded once from sbit to dbit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld  <= 1'b0;
      err_type <= ERR_NONE;
      err_addr <= '0;
    end else if ((acc_sbit || acc_dbit) &&
                 (clr_err || !err_vld || (err_type == ERR_SBIT && acc_dbit))) begin
      err_vld  <= 1'b1;
      err_type <= new_type;
      err_addr <= in_addr;
    end else if (clr_err) begin
      err_vld  <= 1'b0;
      err_type <= ERR_NONE;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_ecc_42_rd_stage.sv
// Directed self-checking bench for ecc_42_rd_stage.
module tb_ecc_42_rd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [41:0] in_data;
  logic        in_sbit_err;
  logic        in_dbit_err;
  logic [5:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [41:0] out_data;
  logic        out_dbit_err;
  logic        clr_err;
  logic [7:0]  sbit_cnt;
  logic [7:0]  dbit_cnt;
  logic        err_vld;
  logic [1:0]  err_type;
  logic [5:0]  err_addr;
  logic        irq_dbit;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  ecc_42_rd_stage #(
    .DATA_WIDTH (42),
    .ADDR_WIDTH (6),
    .CNT_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sbit_err  (in_sbit_err),
    .in_dbit_err  (in_dbit_err),
    .in_addr      (in_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dbit_err (out_dbit_err),
    .clr_err      (clr_err),
    .sbit_cnt     (sbit_cnt),
    .dbit_cnt     (dbit_cnt),
    .err_vld      (err_vld),
    .err_type     (err_type),
    .err_addr     (err_addr),
    .irq_dbit     (irq_dbit)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [41:0] d, input logic [5:0] a,
                       input logic sb, input logic db);
    in_valid    = v;
    in_data     = d;
    in_addr     = a;
    in_sbit_err = sb;
    in_dbit_err = db;
  endtask

  task automatic check_idle_status(input string tag);
    check({tag, "_sbit_cnt"}, 64'(sbit_cnt), 64'd0);
    check({tag, "_dbit_cnt"}, 64'(dbit_cnt), 64'd0);
    check({tag, "_err_vld"},  64'(err_vld),  64'd0);
    check({tag, "_err_type"}, 64'(err_type), 64'd0);
    check({tag, "_err_addr"}, 64'(err_addr), 64'd0);
    check({tag, "_irq"},      64'(irq_dbit), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    check("rst_in_ready",  64'(in_ready),     64'd1);
    check("rst_out_valid", 64'(out_valid),    64'd0);
    check("rst_out_data",  64'(out_data),     64'd0);
    check("rst_out_dbit",  64'(out_dbit_err), 64'd0);
    check_idle_status("rst");
    rst_n = 1'b1;

    // Streaming, no backpressure: each word visible one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 42'(i), 6'(i), 1'b0, 1'b0);
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data",  64'(out_data),  64'(i));
      check("stream_ready", 64'(in_ready),  64'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    step();
    check("stream_drain_valid", 64'(out_valid), 64'd0);
    check_idle_status("stream");

    // Backpressure: two words fill the buffer, the third is refused.
    out_ready = 1'b0;
    drive(1'b1, 42'd100, 6'd0, 1'b0, 1'b0);
    step();
    check("bp_ready_1", 64'(in_ready), 64'd1);
    drive(1'b1, 42'd101, 6'd1, 1'b0, 1'b0);
    step();
    check("bp_ready_2", 64'(in_ready), 64'd0);
    drive(1'b1, 42'd102, 6'd2, 1'b0, 1'b0);
    step();
    check("bp_ready_3", 64'(in_ready),  64'd0);
    check("bp_hold",    64'(out_data),  64'd100);
    check("bp_valid",   64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_out_1",   64'(out_data), 64'd101);
    check("bp_ready_4", 64'(in_ready), 64'd1);
    step();
    check("bp_out_2",   64'(out_data),  64'd102);
    check("bp_valid_2", 64'(out_valid), 64'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Capture: first sbit kept, second sbit ignored, dbit upgrades.
    drive(1'b1, 42'h155, 6'd5, 1'b1, 1'b0);
    step();
    check("cap1_vld",  64'(err_vld),  64'd1);
    check("cap1_type", 64'(err_type), 64'd1);
    check("cap1_addr", 64'(err_addr), 64'd5);
    check("cap1_irq",  64'(irq_dbit), 64'd0);
    check("cap1_poison", 64'(out_dbit_err), 64'd0);
    drive(1'b1, 42'h199, 6'd9, 1'b1, 1'b0);
    step();
    check("cap2_type", 64'(err_type), 64'd1);
    check("cap2_addr", 64'(err_addr), 64'd5);
    check("cap2_scnt", 64'(sbit_cnt), 64'd2);
    drive(1'b1, 42'h3FF_FFFF_FFFF, 6'd12, 1'b0, 1'b1);
    step();
    check("cap3_type",   64'(err_type),     64'd2);
    check("cap3_addr",   64'(err_addr),     64'd12);
    check("cap3_dcnt",   64'(dbit_cnt),     64'd1);
    check("cap3_irq",    64'(irq_dbit),     64'd1);
    check("cap3_poison", 64'(out_dbit_err), 64'd1);
    check("cap3_data",   64'(out_data),     64'h3FF_FFFF_FFFF);
    // Both flags on one word: dbit only, capture already holds a dbit.
    drive(1'b1, 42'h20, 6'd20, 1'b1, 1'b1);
    step();
    check("both_scnt", 64'(sbit_cnt), 64'd2);
    check("both_dcnt", 64'(dbit_cnt), 64'd2);
    check("both_addr", 64'(err_addr), 64'd12);
    // Flags with in_valid low are ignored.
    drive(1'b0, '0, 6'd30, 1'b1, 1'b1);
    step();
    check("novalid_scnt", 64'(sbit_cnt), 64'd2);
    check("novalid_dcnt", 64'(dbit_cnt), 64'd2);

    // Clear colliding with an accepted dbit word: new error wins.
    clr_err = 1'b1;
    drive(1'b1, 42'h33, 6'd3, 1'b0, 1'b1);
    step();
    clr_err = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("clr_dcnt", 64'(dbit_cnt), 64'd1);
    check("clr_scnt", 64'(sbit_cnt), 64'd0);
    check("clr_vld",  64'(err_vld),  64'd1);
    check("clr_type", 64'(err_type), 64'd2);
    check("clr_addr", 64'(err_addr), 64'd3);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check_idle_status("clr_plain");

    // Saturation: 260 accepted sbit words stop at 255.
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 42'(i), 6'(i), 1'b1, 1'b0);
      step();
      if (i == 253) check("sat_254", 64'(sbit_cnt), 64'd254);
      if (i == 254) check("sat_255", 64'(sbit_cnt), 64'd255);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    check("sat_final", 64'(sbit_cnt), 64'd255);
    check("sat_dcnt",  64'(dbit_cnt), 64'd0);
    check("sat_addr",  64'(err_addr), 64'd0);
    check("sat_type",  64'(err_type), 64'd1);

    // Async reset while the buffer holds two words.
    out_ready = 1'b0;
    drive(1'b1, 42'h111, 6'd1, 1'b0, 1'b1);
    step();
    drive(1'b1, 42'h222, 6'd2, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_rst_ready", 64'(in_ready), 64'd0);
    check("pre_rst_irq",   64'(irq_dbit), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready),  64'd1);
    check_idle_status("arst");
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 42'h2AB, 6'd7, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("post_rst_valid",  64'(out_valid),    64'd1);
    check("post_rst_data",   64'(out_data),     64'h2AB);
    check("post_rst_poison", 64'(out_dbit_err), 64'd0);
    step();
    check("post_rst_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
